// File: rtl/tisc_pkg.sv
// Shared widths and types for the TISC writeback path.
// Optional feature macro used by the writeback files: WB_BYPASS_EN.
package tisc_pkg;

  localparam int REG_ADDR_W = 4;
  localparam int DATA_W     = 8;
  localparam int NUM_REGS   = 8;
  localparam int LDQ_DEPTH  = 2;
  localparam int AGE_MAX    = 3;

  localparam int REG_IDX_W  = $clog2(NUM_REGS);
  localparam int CNT_W      = $clog2(LDQ_DEPTH + 1);
  localparam int PTR_W      = $clog2(LDQ_DEPTH);
  localparam int AGE_W      = $clog2(AGE_MAX + 1);

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0]     data_t;

  typedef struct packed {
    reg_addr_t addr;
    data_t     data;
  } wb_req_t;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_ALU,
    SRC_LOAD
  } wb_src_t;

  // Register file only implements the lower NUM_REGS addresses.
  function automatic logic addr_in_range(input reg_addr_t addr);
    return int'(addr) < NUM_REGS;
  endfunction

endpackage

// File: rtl/writeback_unit_if.sv
// Handshake and register-file bundle between decode/execute/memory and the writeback unit.
// WB_BYPASS_EN adds the decode bypass read ports.
interface writeback_unit_if;
  import tisc_pkg::*;

  logic                 alu_valid;
  logic                 alu_ready;
  reg_addr_t            alu_addr;
  data_t                alu_data;
  logic                 ld_issue;
  reg_addr_t            ld_issue_addr;
  logic                 ld_valid;
  logic                 ld_ready;
  reg_addr_t            ld_addr;
  data_t                ld_data;
  logic                 wr_en;
  reg_addr_t            wr_addr;
  data_t                wr_data;
  logic [NUM_REGS-1:0]  pending;
  logic [CNT_W-1:0]     ldq_count;
`ifdef WB_BYPASS_EN
  reg_addr_t            byp_raddr_1;
  reg_addr_t            byp_raddr_2;
  logic                 byp_hit_1;
  logic                 byp_hit_2;
  data_t                byp_data_1;
  data_t                byp_data_2;
`endif

  modport master (
    output alu_valid, alu_addr, alu_data, ld_issue, ld_issue_addr,
           ld_valid, ld_addr, ld_data,
    input  alu_ready, ld_ready, wr_en, wr_addr, wr_data, pending, ldq_count
`ifdef WB_BYPASS_EN
    , output byp_raddr_1, byp_raddr_2,
    input  byp_hit_1, byp_hit_2, byp_data_1, byp_data_2
`endif
  );

  modport slave (
    input  alu_valid, alu_addr, alu_data, ld_issue, ld_issue_addr,
           ld_valid, ld_addr, ld_data,
    output alu_ready, ld_ready, wr_en, wr_addr, wr_data, pending, ldq_count
`ifdef WB_BYPASS_EN
    , input byp_raddr_1, byp_raddr_2,
    output byp_hit_1, byp_hit_2, byp_data_1, byp_data_2
`endif
  );

endinterface

// File: rtl/wb_load_queue.sv
// Two-entry FIFO for returning load data; head is presented combinationally.
// Simultaneous push and pop on a full queue is legal.
module wb_load_queue
  import tisc_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  wb_req_t          push_req,
  input  logic             pop,
  output wb_req_t          head,
  output logic             head_valid,
  output logic [CNT_W-1:0] count
);

  wb_req_t          mem [LDQ_DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign head_valid = (count != '0);
  assign head       = mem[rd_ptr];
  assign do_pop     = pop && head_valid;
  assign do_push    = push && ((count != CNT_W'(LDQ_DEPTH)) || do_pop);

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(LDQ_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // NOTE: storage is deliberately not reset; count/pointers define validity,
  // and a plain clocked array maps onto cheap register/RAM cells.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_req;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/writeback_unit.sv
// TISC writeback stage: ALU/load arbitration into the single register-file
// write port, pending-load scoreboard, load-age guard. Optional: WB_BYPASS_EN.
module writeback_unit
  import tisc_pkg::*;
(
  input logic             clk,
  input logic             rst,
  writeback_unit_if.slave wb
);

  wb_req_t             head;
  logic                head_valid;
  logic [CNT_W-1:0]    count;
  logic [AGE_W-1:0]    age;
  wb_src_t             src;
  wb_req_t             win_req;
  logic                force_ld;
  logic                pop;
  logic                push;
  logic                commit;
  logic [NUM_REGS-1:0] set_mask;
  logic [NUM_REGS-1:0] clr_mask;

  logic                wr_en_q;
  reg_addr_t           wr_addr_q;
  data_t               wr_data_q;
  logic [NUM_REGS-1:0] pending_q;

  wb_load_queue u_ldq (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_req   ('{addr: wb.ld_addr, data: wb.ld_data}),
    .pop        (pop),
    .head       (head),
    .head_valid (head_valid),
    .count      (count)
  );

  // NOTE: every always_comb output gets a default first so no path can
  // leave a variable unassigned and infer a latch.
  always_comb begin
    src      = SRC_NONE;
    set_mask = '0;
    clr_mask = '0;
    force_ld = head_valid && ((count == CNT_W'(LDQ_DEPTH)) || (age == AGE_W'(AGE_MAX)));

    if (force_ld)          src = SRC_LOAD;
    else if (wb.alu_valid) src = SRC_ALU;
    else if (head_valid)   src = SRC_LOAD;

    pop     = (src == SRC_LOAD);
    win_req = (src == SRC_ALU) ? '{addr: wb.alu_addr, data: wb.alu_data} : head;
    // Out-of-range destinations are consumed but never reach the register file.
    commit  = (src != SRC_NONE) && addr_in_range(win_req.addr);

    if (wb.ld_issue && addr_in_range(wb.ld_issue_addr))
      set_mask[wb.ld_issue_addr[REG_IDX_W-1:0]] = 1'b1;
    if (pop && addr_in_range(head.addr))
      clr_mask[head.addr[REG_IDX_W-1:0]] = 1'b1;
  end

  // Handshakes are held low for the whole reset window.
  assign wb.alu_ready = !rst && !force_ld;
  assign wb.ld_ready  = !rst && ((count != CNT_W'(LDQ_DEPTH)) || pop);
  assign push         = wb.ld_valid && wb.ld_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      pending_q <= '0;
      age       <= '0;
    end else begin
      wr_en_q <= commit;
      if (commit) begin
        wr_addr_q <= win_req.addr;
        wr_data_q <= win_req.data;
      end
      // Set wins over clear when both hit the same register.
      pending_q <= (pending_q & ~clr_mask) | set_mask;
      if (!head_valid || pop)
        age <= '0;
      else if ((src == SRC_ALU) && (age != AGE_W'(AGE_MAX)))
        age <= age + 1'b1;
    end
  end

  assign wb.wr_en     = wr_en_q;
  assign wb.wr_addr   = wr_addr_q;
  assign wb.wr_data   = wr_data_q;
  assign wb.pending   = pending_q;
  assign wb.ldq_count = count;

`ifdef WB_BYPASS_EN
  assign wb.byp_hit_1  = wr_en_q && (wr_addr_q == wb.byp_raddr_1);
  assign wb.byp_hit_2  = wr_en_q && (wr_addr_q == wb.byp_raddr_2);
  assign wb.byp_data_1 = wr_data_q;
  assign wb.byp_data_2 = wr_data_q;
`endif

endmodule

// File: tb/tb_writeback_unit.sv
// Directed self-checking bench for writeback_unit; expected values are hand-derived.
// Exercises the WB_BYPASS_EN ports only when that macro is defined.
module tb_writeback_unit;
  import tisc_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  writeback_unit_if bus ();

  writeback_unit dut (
    .clk (clk),
    .rst (rst),
    .wb  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.alu_valid     = 1'b0;
    bus.alu_addr      = '0;
    bus.alu_data      = '0;
    bus.ld_issue      = 1'b0;
    bus.ld_issue_addr = '0;
    bus.ld_valid      = 1'b0;
    bus.ld_addr       = '0;
    bus.ld_data       = '0;
`ifdef WB_BYPASS_EN
    bus.byp_raddr_1   = '0;
    bus.byp_raddr_2   = '0;
`endif
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    clear_inputs();
    rst = 1'b1;

    // Reset state, handshakes forced low even with requests present.
    bus.alu_valid = 1'b1;
    bus.ld_valid  = 1'b1;
    #3;
    check("rst_wr_en",     bus.wr_en,     0);
    check("rst_pending",   bus.pending,   0);
    check("rst_count",     bus.ldq_count, 0);
    check("rst_alu_ready", bus.alu_ready, 0);
    check("rst_ld_ready",  bus.ld_ready,  0);
    clear_inputs();
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("post_rst_alu_ready", bus.alu_ready, 1);
    check("post_rst_ld_ready",  bus.ld_ready,  1);
    check("post_rst_pending",   bus.pending,   0);

    // Back-to-back ALU stream, one write per cycle.
    for (int i = 0; i < 5; i++) begin
      bus.alu_valid = 1'b1;
      bus.alu_addr  = reg_addr_t'(i + 1);
      bus.alu_data  = data_t'(8'h10 + i);
      #1;
      check("alu_stream_ready", bus.alu_ready, 1);
      tick();
      check("alu_stream_en",   bus.wr_en,   1);
      check("alu_stream_addr", bus.wr_addr, i + 1);
      check("alu_stream_data", bus.wr_data, 8'h10 + i);
    end
    bus.alu_valid = 1'b0;
    tick();
    check("alu_idle_en", bus.wr_en, 0);

    // Load path: issue, return, write two edges after the push.
    bus.ld_issue      = 1'b1;
    bus.ld_issue_addr = 4'd3;
    tick();
    bus.ld_issue = 1'b0;
    check("ld_pending_set", bus.pending, 8'h08);
    bus.ld_valid = 1'b1;
    bus.ld_addr  = 4'd3;
    bus.ld_data  = 8'hA5;
    #1;
    check("ld_ready_empty", bus.ld_ready, 1);
    tick();
    bus.ld_valid = 1'b0;
    check("ld_push_count", bus.ldq_count, 1);
    check("ld_push_no_wr", bus.wr_en,     0);
    tick();
    check("ld_wr_en",      bus.wr_en,     1);
    check("ld_wr_addr",    bus.wr_addr,   3);
    check("ld_wr_data",    bus.wr_data,   8'hA5);
    check("ld_pending_clr", bus.pending,  0);
    check("ld_drained",    bus.ldq_count, 0);

    // Starvation guard: ALU wins three times, then the load is forced.
    bus.ld_issue      = 1'b1;
    bus.ld_issue_addr = 4'd4;
    bus.ld_valid      = 1'b1;
    bus.ld_addr       = 4'd4;
    bus.ld_data       = 8'h44;
    bus.alu_valid     = 1'b1;
    bus.alu_addr      = 4'd6;
    bus.alu_data      = 8'h60;
    tick();
    bus.ld_issue = 1'b0;
    bus.ld_valid = 1'b0;
    check("starve_count",   bus.ldq_count, 1);
    check("starve_pending", bus.pending,   8'h10);
    check("starve_first",   bus.wr_data,   8'h60);
    for (int j = 0; j < 3; j++) begin
      bus.alu_data = data_t'(8'h61 + j);
      #1;
      check("starve_alu_ready", bus.alu_ready, 1);
      tick();
      check("starve_alu_data", bus.wr_data, 8'h61 + j);
    end
    bus.alu_data = 8'h70;
    #1;
    check("starve_blocked", bus.alu_ready, 0);
    tick();
    check("starve_ld_en",      bus.wr_en,     1);
    check("starve_ld_addr",    bus.wr_addr,   4);
    check("starve_ld_data",    bus.wr_data,   8'h44);
    check("starve_pending_clr", bus.pending,  0);
    #1;
    check("starve_resume_ready", bus.alu_ready, 1);
    tick();
    check("starve_resume_addr", bus.wr_addr, 6);
    check("starve_resume_data", bus.wr_data, 8'h70);

    // Full queue: push+pop in the same cycle keeps occupancy at 2.
    bus.alu_addr = 4'd7;
    bus.alu_data = 8'h80;
    bus.ld_valid = 1'b1;
    bus.ld_addr  = 4'd1;
    bus.ld_data  = 8'h11;
    tick();
    check("full_alu0", bus.wr_data, 8'h80);
    bus.alu_data = 8'h81;
    bus.ld_addr  = 4'd2;
    bus.ld_data  = 8'h22;
    tick();
    check("full_alu1",  bus.wr_data,   8'h81);
    check("full_count", bus.ldq_count, 2);
    bus.alu_data = 8'h82;
    bus.ld_addr  = 4'd5;
    bus.ld_data  = 8'h55;
    #1;
    check("full_alu_ready", bus.alu_ready, 0);
    check("full_ld_ready",  bus.ld_ready,  1);
    tick();
    bus.ld_valid = 1'b0;
    check("full_pop_addr",   bus.wr_addr,   1);
    check("full_pop_data",   bus.wr_data,   8'h11);
    check("full_push_count", bus.ldq_count, 2);
    tick();
    check("full_pop2_data", bus.wr_data,   8'h22);
    check("full_pop2_cnt",  bus.ldq_count, 1);
    tick();
    check("full_alu_after", bus.wr_data, 8'h82);
    bus.alu_valid = 1'b0;
    tick();
    check("full_last_addr", bus.wr_addr,   5);
    check("full_last_data", bus.wr_data,   8'h55);
    check("full_empty",     bus.ldq_count, 0);

    // Out-of-range: ALU to r9, load to r12 are consumed without a write.
    bus.alu_valid = 1'b1;
    bus.alu_addr  = 4'd9;
    bus.alu_data  = 8'h99;
    #1;
    check("oor_alu_ready", bus.alu_ready, 1);
    tick();
    bus.alu_valid = 1'b0;
    check("oor_alu_no_wr", bus.wr_en, 0);
    bus.ld_issue      = 1'b1;
    bus.ld_issue_addr = 4'd12;
    bus.ld_valid      = 1'b1;
    bus.ld_addr       = 4'd12;
    bus.ld_data       = 8'hCC;
    tick();
    clear_inputs();
    check("oor_issue_pending", bus.pending, 0);
    tick();
    check("oor_ld_no_wr", bus.wr_en,     0);
    check("oor_ld_drain", bus.ldq_count, 0);

    // Set wins over clear on the same register.
    bus.ld_issue      = 1'b1;
    bus.ld_issue_addr = 4'd2;
    bus.ld_valid      = 1'b1;
    bus.ld_addr       = 4'd2;
    bus.ld_data       = 8'h2B;
    tick();
    bus.ld_valid = 1'b0;
    check("setwin_pre", bus.pending, 8'h04);
    tick();
    bus.ld_issue = 1'b0;
    check("setwin_wr_addr", bus.wr_addr, 2);
    check("setwin_pending", bus.pending, 8'h04);

`ifdef WB_BYPASS_EN
    bus.byp_raddr_1 = 4'd2;
    bus.byp_raddr_2 = 4'd3;
    #1;
    check("byp_hit_1",  bus.byp_hit_1,  1);
    check("byp_hit_2",  bus.byp_hit_2,  0);
    check("byp_data_1", bus.byp_data_1, 8'h2B);
`endif

    // Asynchronous reset in mid-cycle with a load queued and a bit pending.
    bus.ld_valid = 1'b1;
    bus.ld_addr  = 4'd6;
    bus.ld_data  = 8'h66;
    bus.alu_valid = 1'b1;
    bus.alu_addr  = 4'd1;
    bus.alu_data  = 8'h01;
    tick();
    bus.ld_valid = 1'b0;
    check("mid_pre_count", bus.ldq_count, 1);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_wr_en",   bus.wr_en,     0);
    check("mid_rst_wr_addr", bus.wr_addr,   0);
    check("mid_rst_wr_data", bus.wr_data,   0);
    check("mid_rst_pending", bus.pending,   0);
    check("mid_rst_count",   bus.ldq_count, 0);
    check("mid_rst_alu_rdy", bus.alu_ready, 0);
    check("mid_rst_ld_rdy",  bus.ld_ready,  0);
    clear_inputs();
    tick();
    rst = 1'b0;
    #1;
    check("mid_rel_alu_rdy", bus.alu_ready, 1);
    check("mid_rel_ld_rdy",  bus.ld_ready,  1);
    tick();
    check("mid_rel_idle", bus.wr_en, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
